piece_spawner: RTL and testbench
================================

// Module: piece_spawner
// PURPOSE
//  Produces each new falling tetromino. Picks the next piece and drives the anchor position and
//  4x4 float mask to the game-over checker. Samples the checker's verdict, then reports one of two
//  results: spawn complete, or game over (latched).
//  Sits between the game-control FSM (spawn_req/restart) and the game-over checker.
// PARAMETERS
//  SPAWN_X    4'd3        anchor column loaded on every spawn
//  SPAWN_Y    5'd0        anchor row loaded on every spawn
//  CHECK_LAT  1           cycles from mask load to sampling game_over_in; legal range 1..15
//  LFSR_SEED  16'hACE1    LFSR reset value; must be non-zero
// PORTS
//  clk           in   1   system clock, all state on rising edge
//  rst_n         in   1   asynchronous active-low reset
//  spawn_req     in   1   request a new piece; sampled only in IDLE
//  restart       in   1   leave OVER; sampled only in OVER
//  game_over_in  in   1   verdict from the game-over checker for the current pos/float
//  pos_x         out  4   anchor column of the spawned piece
//  pos_y         out  5   anchor row of the spawned piece
//  float         out  16  [0:15] mask, index = row*4+col, row 0 on top
//  piece_id      out  3   id of the spawned piece (0..6)
//  next_id       out  3   preview of the following piece (0..6)
//  busy          out  1   high in CHECK
//  spawn_done    out  1   one-cycle pulse: spawn accepted, no game over
//  game_over     out  1   latched game-over flag, high in OVER
// BEHAVIOUR
//  Reset values: pos_x=SPAWN_X, pos_y=SPAWN_Y, float=16'h0000, piece_id=0, busy=0,
//   spawn_done=0, game_over=0, state=IDLE, lfsr=LFSR_SEED. next_id is computed from LFSR_SEED.
//  Piece table (rotation 0, index 0 = MSB):
//   0 I = 0000_1111_0000_0000    1 O = 0110_0110_0000_0000    2 T = 0100_1110_0000_0000
//   3 S = 0110_1100_0000_0000    4 Z = 1100_0110_0000_0000    5 J = 1000_1110_0000_0000
//   6 L = 0010_1110_0000_0000
//  LFSR: 16-bit Galois, taps x^16+x^14+x^13+x^11. It advances every clock in every state.
//  Candidate id c:
//   - c = lfsr[2:0] if that value is not 7
//   - otherwise c = lfsr[5:3] if that value is not 7
//   - otherwise c = 0
//  FSM states: IDLE, CHECK, OVER.
//  IDLE, spawn_req=1 at edge k:
//   - registered at edge k: piece_id<=next_id, float<=table[next_id], pos<=(SPAWN_X,SPAWN_Y),
//     next_id<=c, cnt<=CHECK_LAT-1
//   - go to CHECK; busy=1 from edge k
//  CHECK:
//   - while cnt!=0: cnt decrements each edge
//   - when cnt==0, game_over_in is sampled at that edge, edge k+CHECK_LAT:
//     0 -> IDLE, spawn_done=1 for exactly one cycle, busy=0
//     1 -> OVER, game_over=1, busy=0
//  OVER:
//   - outputs hold their values; spawn_req is ignored
//   - restart=1 -> IDLE, game_over=0
//  Outputs pos/float/piece_id hold the last spawn until the next accepted spawn_req.
//  Boundary conditions:
//   - spawn_req while busy or in OVER: dropped, not queued
//   - restart outside OVER: ignored
//   - restart and spawn_req in the same cycle in OVER: restart wins, spawn_req dropped
//   - rst_n low at any time, including mid-CHECK: immediately returns every register to its reset
//     value; no spawn_done is produced
// CONFIGURATION
//  SPAWN_7BAG_EN defined: adds a 7-bit used mask, cleared at reset and on restart.
//   - on spawn, next_id = the first unused id at or after c, searching modulo 7; that id is
//     marked used
//   - once all 7 bits are set, the mask is cleared in the same edge
//   - every aligned group of 7 spawns is a permutation of 0..6
//  SPAWN_7BAG_EN undefined: next_id = c directly; no used-mask logic.
// TESTING
//  1 Reset asserted -> float=0, pos=(3,0), busy=0, spawn_done=0, game_over=0.
//  2 CHECK_LAT=1, spawn_req pulse, game_over_in=0 -> busy for 1 cycle, spawn_done high on cycle
//    k+1, float==table[piece_id], piece_id equals the previous next_id.
//  3 CHECK_LAT=3, game_over_in=1 -> game_over latches at k+3. Further spawn_req produces no
//    change. restart -> game_over=0, state IDLE.
//  4 spawn_req held high 5 cycles with CHECK_LAT=2 -> exactly 2 spawn_done pulses; the
//    request during CHECK is dropped.
//  5 rst_n pulled low mid-CHECK -> outputs at reset values asynchronously; no spawn_done after
//    release.
//  6 SPAWN_7BAG_EN: 14 consecutive spawns -> ids 1-7 and ids 8-14 are each a permutation of 0..6.

Source files
------------

// File: rtl/piece_spawner.sv
// rtl/piece_spawner.sv - tetromino spawner: LFSR piece pick, float mask load, game-over verdict
// Optional feature: define SPAWN_7BAG_EN for 7-bag randomisation of the preview piece.
module piece_spawner #(
  parameter logic [3:0]  SPAWN_X   = 4'd3,
  parameter logic [4:0]  SPAWN_Y   = 5'd0,
  parameter int          CHECK_LAT = 1,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        spawn_req,
  input  logic        restart,
  input  logic        game_over_in,
  output logic [3:0]  pos_x,
  output logic [4:0]  pos_y,
  output logic [15:0] float,
  output logic [2:0]  piece_id,
  output logic [2:0]  next_id,
  output logic        busy,
  output logic        spawn_done,
  output logic        game_over
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_CHECK = 2'd1;
  localparam logic [1:0] ST_OVER  = 2'd2;

  localparam logic [3:0] CNT_LOAD = 4'(CHECK_LAT - 1);

  // Galois form, taps x^16+x^14+x^13+x^11, shifting right
  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return {1'b0, v[15:1]} ^ (v[0] ? 16'hB400 : 16'h0000);
  endfunction

  function automatic logic [2:0] lfsr_pick(input logic [15:0] v);
    if (v[2:0] != 3'd7)      return v[2:0];
    else if (v[5:3] != 3'd7) return v[5:3];
    else                     return 3'd0;
  endfunction

  // Rotation-0 shapes, bit 15 = row 0 col 0
  function automatic logic [15:0] piece_mask(input logic [2:0] id);
    case (id)
      3'd0:    return 16'h0F00;
      3'd1:    return 16'h6600;
      3'd2:    return 16'h4E00;
      3'd3:    return 16'h6C00;
      3'd4:    return 16'hC600;
      3'd5:    return 16'h8E00;
      3'd6:    return 16'h2E00;
      default: return 16'h0000;
    endcase
  endfunction

  logic [1:0]  state;
  logic [3:0]  cnt;
  logic [15:0] lfsr;
  logic [2:0]  cand;
  logic [2:0]  new_next;

  assign cand = lfsr_pick(lfsr);

`ifdef SPAWN_7BAG_EN
  logic [6:0] used;
  logic [6:0] used_upd;
  logic [2:0] bag_id;
  logic [3:0] bag_idx;
  logic       bag_found;

  // First unused id at or after cand, wrapping modulo 7
  always_comb begin
    bag_id    = cand;
    bag_found = 1'b0;
    bag_idx   = 4'd0;
    for (int i = 0; i < 7; i++) begin
      bag_idx = {1'b0, cand} + 4'(i);
      if (bag_idx >= 4'd7) bag_idx = bag_idx - 4'd7;
      if (!bag_found && !used[bag_idx[2:0]]) begin
        bag_id    = bag_idx[2:0];
        bag_found = 1'b1;
      end
    end
    used_upd = used | (7'd1 << bag_id);
    if (used_upd == 7'h7F) used_upd = 7'h00;
  end

  assign new_next = bag_id;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      used <= 7'h00;
    end else if (state == ST_IDLE && spawn_req) begin
      used <= used_upd;
    end else if (state == ST_OVER && restart) begin
      used <= 7'h00;
    end
  end
`else
  assign new_next = cand;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      cnt        <= 4'd0;
      lfsr       <= LFSR_SEED;
      pos_x      <= SPAWN_X;
      pos_y      <= SPAWN_Y;
      float      <= 16'h0000;
      piece_id   <= 3'd0;
      next_id    <= lfsr_pick(LFSR_SEED);
      spawn_done <= 1'b0;
    end else begin
      lfsr       <= lfsr_step(lfsr);
      spawn_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (spawn_req) begin
            piece_id <= next_id;
            float    <= piece_mask(next_id);
            pos_x    <= SPAWN_X;
            pos_y    <= SPAWN_Y;
            next_id  <= new_next;
            cnt      <= CNT_LOAD;
            state    <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else if (game_over_in) begin
            state <= ST_OVER;
          end else begin
            state      <= ST_IDLE;
            spawn_done <= 1'b1;
          end
        end
        ST_OVER: begin
          if (restart) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign busy      = (state == ST_CHECK);
  assign game_over = (state == ST_OVER);

endmodule

// File: tb/tb_piece_spawner.sv
// tb/tb_piece_spawner.sv - directed bench for piece_spawner at CHECK_LAT 1, 2 and 3
// Define SPAWN_7BAG_EN to also exercise the 7-bag preview sequence.
module tb_piece_spawner;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic spawn_req = 1'b0;
  logic restart = 1'b0;
  logic game_over_in = 1'b0;

  logic [3:0]  pos_x      [3];
  logic [4:0]  pos_y      [3];
  logic [15:0] float_mask [3];
  logic [2:0]  piece_id   [3];
  logic [2:0]  next_id    [3];
  logic        busy       [3];
  logic        spawn_done [3];
  logic        game_over  [3];

  int n_cmp = 0;
  int n_bad = 0;

  logic [15:0] shapes [7] = '{16'h0F00, 16'h6600, 16'h4E00, 16'h6C00,
                              16'hC600, 16'h8E00, 16'h2E00};

  always #5 clk = ~clk;

  // Instance g has CHECK_LAT = g+1
  for (genvar g = 0; g < 3; g++) begin : g_dut
    piece_spawner #(.CHECK_LAT(g + 1)) u_dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .spawn_req    (spawn_req),
      .restart      (restart),
      .game_over_in (game_over_in),
      .pos_x        (pos_x[g]),
      .pos_y        (pos_y[g]),
      .float        (float_mask[g]),
      .piece_id     (piece_id[g]),
      .next_id      (next_id[g]),
      .busy         (busy[g]),
      .spawn_done   (spawn_done[g]),
      .game_over    (game_over[g])
    );
  end

  logic [15:0] m_lfsr;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m_lfsr <= 16'hACE1;
    else        m_lfsr <= {1'b0, m_lfsr[15:1]} ^ ({16{m_lfsr[0]}} & 16'hB400);
  end

  function automatic logic [2:0] model_pick(input logic [15:0] v);
    if (v[2:0] != 3'd7)      return v[2:0];
    else if (v[5:3] != 3'd7) return v[5:3];
    else                     return 3'd0;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expd);
    n_cmp++;
    if (obs !== expd) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, expd);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

`ifdef SPAWN_7BAG_EN
  localparam int N_SPAWN = 1;
`else
  localparam int N_SPAWN = 3;
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [2:0] cur_next;
    logic [2:0] exp_next;
    logic [2:0] exp_piece;
    logic [2:0] e3;
    int pulses;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    check("rst_float",    32'(float_mask[0]), 32'h0000);
    check("rst_pos_x",    32'(pos_x[0]), 32'd3);
    check("rst_pos_y",    32'(pos_y[0]), 32'd0);
    check("rst_piece_id", 32'(piece_id[0]), 32'd0);
    check("rst_next_id",  32'(next_id[0]), 32'd1);
    check("rst_busy",     32'(busy[0]), 32'd0);
    check("rst_done",     32'(spawn_done[0]), 32'd0);
    check("rst_over",     32'(game_over[0]), 32'd0);
    rst_n = 1'b1;

    // CHECK_LAT=1 spawns, checker says no game over
    cur_next = 3'd1;
    for (int s = 0; s < N_SPAWN; s++) begin
      @(negedge clk);
      exp_next  = model_pick(m_lfsr);
      exp_piece = cur_next;
      spawn_req = 1'b1;
      @(negedge clk);
      spawn_req = 1'b0;
      check("l1_busy",     32'(busy[0]), 32'd1);
      check("l1_done_k",   32'(spawn_done[0]), 32'd0);
      check("l1_piece",    32'(piece_id[0]), 32'(exp_piece));
      check("l1_float",    32'(float_mask[0]), 32'(shapes[exp_piece]));
      check("l1_pos_x",    32'(pos_x[0]), 32'd3);
      check("l1_pos_y",    32'(pos_y[0]), 32'd0);
`ifndef SPAWN_7BAG_EN
      check("l1_next",     32'(next_id[0]), 32'(exp_next));
`endif
      @(negedge clk);
      check("l1_busy_k1",  32'(busy[0]), 32'd0);
      check("l1_done_k1",  32'(spawn_done[0]), 32'd1);
      check("l1_over_k1",  32'(game_over[0]), 32'd0);
      @(negedge clk);
      check("l1_done_k2",  32'(spawn_done[0]), 32'd0);
      check("l1_hold",     32'(float_mask[0]), 32'(shapes[exp_piece]));
      cur_next = exp_next;
    end

    // CHECK_LAT=3, game over
    do_reset();
    @(negedge clk);
    e3 = model_pick(m_lfsr);
    game_over_in = 1'b1;
    spawn_req = 1'b1;
    @(negedge clk);
    spawn_req = 1'b0;
    check("l3_busy_k",   32'(busy[2]), 32'd1);
    check("l3_piece",    32'(piece_id[2]), 32'd1);
    @(negedge clk);
    check("l3_over_k1",  32'(game_over[2]), 32'd0);
    @(negedge clk);
    check("l3_busy_k2",  32'(busy[2]), 32'd1);
    check("l3_over_k2",  32'(game_over[2]), 32'd0);
    @(negedge clk);
    check("l3_over_k3",  32'(game_over[2]), 32'd1);
    check("l3_busy_k3",  32'(busy[2]), 32'd0);
    check("l3_done_k3",  32'(spawn_done[2]), 32'd0);
    game_over_in = 1'b0;
    spawn_req = 1'b1;
    repeat (3) @(negedge clk);
    spawn_req = 1'b0;
    check("l3_ign_piece", 32'(piece_id[2]), 32'd1);
    check("l3_ign_float", 32'(float_mask[2]), 32'h6600);
    check("l3_ign_busy",  32'(busy[2]), 32'd0);
    check("l3_ign_over",  32'(game_over[2]), 32'd1);
    restart = 1'b1;
    spawn_req = 1'b1;
    @(negedge clk);
    restart = 1'b0;
    spawn_req = 1'b0;
    check("l3_rs_over",  32'(game_over[2]), 32'd0);
    check("l3_rs_busy",  32'(busy[2]), 32'd0);
    check("l3_rs_piece", 32'(piece_id[2]), 32'd1);
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
    check("l3_rsidle_over", 32'(game_over[2]), 32'd0);
    spawn_req = 1'b1;
    @(negedge clk);
    spawn_req = 1'b0;
    check("l3_respawn_busy", 32'(busy[2]), 32'd1);
`ifndef SPAWN_7BAG_EN
    check("l3_respawn_piece", 32'(piece_id[2]), 32'(e3));
`endif

    // CHECK_LAT=2, spawn_req held 5 cycles
    do_reset();
    pulses = 0;
    spawn_req = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (c == 4) spawn_req = 1'b0;
      if (spawn_done[1]) pulses++;
    end
    check("l2_pulses", 32'(pulses), 32'd2);

    // Reset asserted mid-CHECK
    do_reset();
    @(negedge clk);
    spawn_req = 1'b1;
    @(negedge clk);
    spawn_req = 1'b0;
    check("ar_busy_pre", 32'(busy[2]), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("ar_busy",  32'(busy[2]), 32'd0);
    check("ar_float", 32'(float_mask[2]), 32'h0000);
    check("ar_piece", 32'(piece_id[2]), 32'd0);
    check("ar_next",  32'(next_id[2]), 32'd1);
    check("ar_pos_x", 32'(pos_x[2]), 32'd3);
    check("ar_over",  32'(game_over[2]), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (spawn_done[2]) pulses++;
    end
    check("ar_no_done", 32'(pulses), 32'd0);

`ifdef SPAWN_7BAG_EN
    begin
      logic [2:0] ids [14];
      logic [6:0] seen;
      do_reset();
      for (int s = 0; s < 14; s++) begin
        @(negedge clk);
        spawn_req = 1'b1;
        @(negedge clk);
        spawn_req = 1'b0;
        ids[s] = next_id[0];
        @(negedge clk);
      end
      for (int grp = 0; grp < 2; grp++) begin
        seen = 7'h00;
        for (int i = 0; i < 7; i++) seen = seen | (7'd1 << ids[grp * 7 + i]);
        check("bag_perm", 32'(seen), 32'h7F);
      end
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
